// File: rtl/prio_pkg.sv
// Shared types and constants for the sequential priority encoder.
package prio_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Search direction for prio_scan
    localparam logic SCAN_UP    = 1'b0;
    localparam logic SCAN_DOWN  = 1'b1;

endpackage

// File: rtl/prio_scan.sv
// Combinational wrapped search: first set bit of req_i starting at start_i,
// walking up or down modulo N.
module prio_scan
    import prio_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [IW-1:0] start_i,
    input  logic          dir_i,
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [N-1:0] up_win;
    logic [N-1:0] dn_win;

    function automatic logic [IW-1:0] wrap_pos(input int p);
        int q;
        q = p;
        if (q < 0) q = q + int'(N);
        else if (q >= int'(N)) q = q - int'(N);
        return IW'(q);
    endfunction

    // up_win[k] = req[(start+k) mod N]; dn_win[N-1-k] = req[(start-k) mod N]
    always_comb begin
        up_win  = N'({req_i, req_i} >> start_i);
        dn_win  = N'({req_i, req_i} >> ((IW+1)'(start_i) + (IW+1)'(1)));
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            if (!found_o) begin
                if (dir_i == SCAN_UP && up_win[k]) begin
                    found_o = 1'b1;
                    idx_o   = wrap_pos(int'(start_i) + k);
                end else if (dir_i == SCAN_DOWN && dn_win[N-1-k]) begin
                    found_o = 1'b1;
                    idx_o   = wrap_pos(int'(start_i) - k);
                end
            end
        end
    end

endmodule

// File: rtl/prio_encoder_seq.sv
// Registered priority encoder with fixed / round-robin arbitration and a
// valid/ready output holding one result until it is transferred.
module prio_encoder_seq
    import prio_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          mode,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [IW-1:0] idx,
    output logic          multi
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] last_q, last_d;
    logic          multi_q, multi_d;

    logic          transfer_c;
    logic          capture_c;
    logic          multi_c;
    logic [IW-1:0] last_eff_c;
    logic [IW-1:0] rr_start_c;
    logic [IW-1:0] scan_start_c;
    logic          scan_dir_c;
    logic [IW-1:0] scan_idx_c;
    logic          scan_found_c;

    // A transferring result becomes "last" for the search in the same cycle
    always_comb begin
        transfer_c   = (state_q == HOLD) && out_ready;
        last_eff_c   = transfer_c ? idx_q : last_q;
        rr_start_c   = (last_eff_c == LAST_IDX) ? '0 : last_eff_c + IW'(1);
        scan_start_c = (mode == MODE_FIXED) ? LAST_IDX : rr_start_c;
        scan_dir_c   = (mode == MODE_FIXED) ? SCAN_DOWN : SCAN_UP;
        multi_c      = (req & (req - N'(1))) != '0;
        capture_c    = ((state_q == IDLE) || transfer_c) && scan_found_c;
    end

    prio_scan #(
        .N  (N),
        .IW (IW)
    ) u_scan (
        .start_i (scan_start_c),
        .dir_i   (scan_dir_c),
        .req_i   (req),
        .idx_o   (scan_idx_c),
        .found_o (scan_found_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            multi_q <= 1'b0;
            last_q  <= LAST_IDX;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            multi_q <= multi_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        multi_d = multi_q;
        last_d  = last_q;
        if (transfer_c) begin
            last_d = idx_q;
        end
        if (capture_c) begin
            state_d = HOLD;
            idx_d   = scan_idx_c;
            multi_d = multi_c;
        end else if (transfer_c) begin
            state_d = IDLE;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign idx       = idx_q;
    assign multi     = multi_q;

endmodule

// File: doc/prio_encoder_seq.md
PRIO_ENCODER_SEQ -- requirements
Module: prio_encoder_seq

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of request inputs, legal range 2..32.
REQ-002 SHALL have parameter IW, default $clog2(N), meaning index width; not overridden by users.
REQ-003 SHALL have port clk, input, 1, meaning single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port req, input, N, meaning request vector; bit i is request i.
REQ-006 SHALL have port mode, input, 1, meaning 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 SHALL have port out_ready, input, 1, meaning consumer accepts the current result.
REQ-008 SHALL have port out_valid, output, 1, meaning idx holds a valid encoded result.
REQ-009 SHALL have port idx, output, IW, meaning encoded index of the granted request.
REQ-010 SHALL have port multi, output, 1, meaning more than one req bit was set when idx was captured.

Function
REQ-011 SHALL implement two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-012 IDLE with req!=0 SHALL capture the encoded idx and multi and enter HOLD on the next edge; latency is 1 cycle from req to out_valid.
REQ-013 IDLE with req==0 SHALL remain in IDLE, with idx and multi unchanged.
REQ-014 HOLD with out_ready=0 SHALL keep idx, multi and out_valid stable and ignore req and mode changes.
REQ-015 HOLD with out_ready=1 (transfer) and req!=0 SHALL re-encode in the same edge and stay in HOLD (back-to-back, one result per cycle).
REQ-016 HOLD with out_ready=1 and req==0 SHALL return to IDLE.
REQ-017 Fixed mode SHALL select the highest set index of req.
REQ-018 Round-robin mode SHALL search upward from (last+1) mod N, wrapping N-1 to 0, and select the first set bit.
REQ-019 last SHALL be updated to the transferred idx on every transfer, in both modes.
REQ-020 The round-robin search in a transfer cycle SHALL use the just-transferred idx as last.
REQ-021 Wrap SHALL be at N-1 for non-power-of-two N; idx SHALL never exceed N-1.
REQ-022 A mode change SHALL take effect at the next capture only.
REQ-023 multi SHALL be 1 when popcount(req) >= 2 at capture, else 0.

Reset
REQ-024 With rst_n=0 at an edge, the block SHALL set state=IDLE, out_valid=0, idx=0, multi=0 and last=N-1, so the first round-robin search starts at 0.
REQ-025 Reset SHALL override a pending transfer or capture in the same cycle, including reset asserted mid-HOLD.

Structure
REQ-026 A shared package prio_pkg SHALL hold the state enum (IDLE, HOLD) and the mode constants MODE_FIXED=0 and MODE_RR=1.
REQ-027 A combinational sub-module prio_scan (N, start index, req -> idx, found) SHALL perform the wrapped search.
REQ-028 Fixed mode SHALL use prio_scan as a downward search from N-1.
REQ-029 Only prio_encoder_seq SHALL hold registers.

Verification
REQ-030 Bench SHALL cover: N=4, mode=0, req=0101, out_ready=1 -> next cycle out_valid=1, idx=2, multi=1.
REQ-031 Bench SHALL cover: N=4, mode=1, after reset, req=1111 held, out_ready=1 -> idx sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 Bench SHALL cover: N=4, mode=1, last=2, req=0101 -> idx=0 (wrap).
REQ-033 Bench SHALL cover: out_ready=0 for 3 cycles while req changes 0001->1000 -> idx stays at the first captured value and out_valid stays 1.
REQ-034 Bench SHALL cover: req=0000 after a transfer -> out_valid=0 next cycle.
REQ-035 Bench SHALL cover: rst_n=0 during HOLD -> out_valid=0, idx=0 next cycle, and the first round-robin grant afterwards is the lowest set bit.
REQ-036 Bench SHALL cover: N=5 with all 5 req bits set in round-robin mode -> idx sequence 0..4, then 0.
